// File: rtl/fht_unload.sv
// Result read-out engine for the FHT core: walks the four result banks row by row
// (natural or bit-reversed order) and serialises each row onto a valid/ready stream.
module fht_unload #(
    parameter int D_BIT  = 22,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic               iBIT_REV,
    output logic [A_BIT-1:0]   oADDR_RD,
    input  logic [D_BIT-1:0]   iDATA_0,
    input  logic [D_BIT-1:0]   iDATA_1,
    input  logic [D_BIT-1:0]   iDATA_2,
    input  logic [D_BIT-1:0]   iDATA_3,
    output logic [D_BIT-1:0]   oDATA,
    output logic               oVALID,
    input  logic               iREADY,
    output logic [A_BIT+1:0]   oIDX,
    output logic               oLAST,
    output logic               oBUSY,
    output logic               oDONE
);

    localparam int CW = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND, ST_FIN} state_t;

    state_t           state_r, state_s;
    logic             rev_r, rev_s;
    logic [A_BIT-1:0] row_r, row_s;
    logic [1:0]       bank_r, bank_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [D_BIT-1:0] latch_r [4];
    logic [D_BIT-1:0] latch_s [4];
    logic [A_BIT-1:0] addr_r, addr_s;
    logic [D_BIT-1:0] data_r, data_s;
    logic             valid_r, valid_s;
    logic [A_BIT+1:0] idx_r, idx_s;
    logic             last_r, last_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic [1:0]       nb_s;
    logic [A_BIT-1:0] row_inc_s;
    logic             row_last_s;

    function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] r;
        r = '0;
        for (int i = 0; i < A_BIT; i++) begin
            r[A_BIT-1-i] = v[i];
        end
        return r;
    endfunction

    assign nb_s       = bank_r + 2'd1;
    assign row_inc_s  = row_r + {{(A_BIT-1){1'b0}}, 1'b1};
    assign row_last_s = (row_r == {A_BIT{1'b1}});

    // Next-state and next-output computation; every output is a flop loaded from here.
    always_comb begin
        state_s = state_r;
        rev_s   = rev_r;
        row_s   = row_r;
        bank_s  = bank_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        data_s  = data_r;
        valid_s = valid_r;
        idx_s   = idx_r;
        last_s  = last_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            latch_s[i] = latch_r[i];
        end
        case (state_r)
            ST_IDLE: begin
                if (iSTART) begin
                    rev_s   = iBIT_REV;
                    row_s   = '0;
                    addr_s  = '0;
                    busy_s  = 1'b1;
                    cnt_s   = CW'(RD_LAT);
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 3'd1;
                // The edge on which the counter hits zero is the one where read data is valid.
                if (cnt_r == 3'd1) begin
                    latch_s[0] = iDATA_0;
                    latch_s[1] = iDATA_1;
                    latch_s[2] = iDATA_2;
                    latch_s[3] = iDATA_3;
                    bank_s     = 2'd0;
                    valid_s    = 1'b1;
                    data_s     = iDATA_0;
                    idx_s      = {row_r, 2'b00};
                    last_s     = 1'b0;
                    state_s    = ST_SEND;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (!iREADY) begin
                    state_s = ST_SEND;
                end else if (bank_r != 2'd3) begin
                    bank_s = nb_s;
                    data_s = latch_r[nb_s];
                    idx_s  = {row_r, nb_s};
                    last_s = row_last_s && (nb_s == 2'd3);
                end else if (!row_last_s) begin
                    row_s   = row_inc_s;
                    addr_s  = rev_r ? bitrev(row_inc_s) : row_inc_s;
                    cnt_s   = CW'(RD_LAT);
                    valid_s = 1'b0;
                    state_s = ST_WAIT;
                end else begin
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_FIN;
                end
            end
            ST_FIN: begin
                busy_s  = 1'b0;
                addr_s  = '0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_r <= ST_IDLE;
            rev_r   <= 1'b0;
            row_r   <= '0;
            bank_r  <= 2'd0;
            cnt_r   <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            idx_r   <= '0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                latch_r[i] <= '0;
            end
        end else begin
            state_r <= state_s;
            rev_r   <= rev_s;
            row_r   <= row_s;
            bank_r  <= bank_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            idx_r   <= idx_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            for (int i = 0; i < 4; i++) begin
                latch_r[i] <= latch_s[i];
            end
        end
    end

    assign oADDR_RD = addr_r;
    assign oDATA    = data_r;
    assign oVALID   = valid_r;
    assign oIDX     = idx_r;
    assign oLAST    = last_r;
    assign oBUSY    = busy_r;
    assign oDONE    = done_r;

endmodule
